// File: rtl/way_replacement_fill.sv
`default_nettype none
// ============================================================================
// Module   : way_replacement_fill
// Purpose  : Tag/valid storage with true-LRU ages per set; reports hit or
//            fills a victim way (first invalid, else LRU) on each request.
// Revision : 1.0 - initial release
// ============================================================================
module way_replacement_fill #(
  parameter  int i_size = 20,
  parameter  int c_size = 12,
  parameter  int a_size = 8,
  parameter  int d_size = 6,
  localparam int IDX    = c_size - d_size - $clog2(a_size),
  localparam int TAG    = i_size - IDX - d_size,
  localparam int WB     = $clog2(a_size)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [i_size-1:0]           req_addr,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic                        resp_hit,
  output logic [WB-1:0]               resp_way,
  output logic                        evict_valid,
  output logic [TAG-1:0]              evict_tag,
  output logic [a_size-1:0][TAG-1:0]  tag_row
);

  localparam int NSETS = 1 << IDX;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [WB-1:0] AGE_LRU = WB'(a_size - 1);

  logic [1:0]               state_q, state_d;

  logic [a_size-1:0]        valid_q [NSETS];
  logic [TAG-1:0]           tags_q  [NSETS][a_size];
  logic [WB-1:0]            ages_q  [NSETS][a_size];

  logic [TAG-1:0]           rtag_q;
  logic [IDX-1:0]           ridx_q;
  logic                     hit_q;
  logic [WB-1:0]            way_q;

  logic                     resp_valid_q;
  logic                     resp_hit_q;
  logic [WB-1:0]            resp_way_q;
  logic                     evict_valid_q;
  logic [TAG-1:0]           evict_tag_q;
  logic [a_size-1:0][TAG-1:0] tag_row_q;

  logic                     lk_hit, lk_inv;
  logic [WB-1:0]            lk_hit_way, lk_inv_way, lk_lru_way, lk_way;
  logic                     unused_offset;

  assign unused_offset = ^req_addr[d_size-1:0];

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!flush && req_valid) state_d = S_LOOKUP;
      S_LOOKUP: state_d = S_UPDATE;
      S_UPDATE: state_d = S_RESP;
      S_RESP:   if (resp_valid_q && resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = rst_n && (state_q == S_IDLE) && !flush;
  end

  // Scan high-to-low so the lowest matching / invalid way is the one kept.
  always_comb begin
    lk_hit     = 1'b0;
    lk_inv     = 1'b0;
    lk_hit_way = '0;
    lk_inv_way = '0;
    lk_lru_way = '0;
    for (int w = a_size - 1; w >= 0; w--) begin
      if (valid_q[ridx_q][w] && (tags_q[ridx_q][w] == rtag_q)) begin
        lk_hit     = 1'b1;
        lk_hit_way = WB'(w);
      end
      if (!valid_q[ridx_q][w]) begin
        lk_inv     = 1'b1;
        lk_inv_way = WB'(w);
      end
      if (ages_q[ridx_q][w] == AGE_LRU) lk_lru_way = WB'(w);
    end
    lk_way = lk_hit ? lk_hit_way : (lk_inv ? lk_inv_way : lk_lru_way);
  end

  // ------------------------------------------------------- storage/datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < NSETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < a_size; w++) begin
          tags_q[s][w] <= '0;
          ages_q[s][w] <= WB'(w);
        end
      end
      rtag_q        <= '0;
      ridx_q        <= '0;
      hit_q         <= 1'b0;
      way_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_way_q    <= '0;
      evict_valid_q <= 1'b0;
      evict_tag_q   <= '0;
      tag_row_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush) begin
            for (int s = 0; s < NSETS; s++) begin
              valid_q[s] <= '0;
              for (int w = 0; w < a_size; w++) ages_q[s][w] <= WB'(w);
            end
          end else if (req_valid) begin
            rtag_q <= req_addr[i_size-1 -: TAG];
            ridx_q <= req_addr[d_size +: IDX];
          end
        end
        S_LOOKUP: begin
          hit_q <= lk_hit;
          way_q <= lk_way;
        end
        S_UPDATE: begin
          for (int w = 0; w < a_size; w++) begin
            if (WB'(w) == way_q)
              ages_q[ridx_q][w] <= '0;
            else if (ages_q[ridx_q][w] < ages_q[ridx_q][way_q])
              ages_q[ridx_q][w] <= ages_q[ridx_q][w] + 1'b1;
            tag_row_q[w] <= (!hit_q && (WB'(w) == way_q)) ? rtag_q : tags_q[ridx_q][w];
          end
          if (!hit_q) begin
            tags_q[ridx_q][way_q]  <= rtag_q;
            valid_q[ridx_q][way_q] <= 1'b1;
            evict_valid_q <= valid_q[ridx_q][way_q];
            evict_tag_q   <= valid_q[ridx_q][way_q] ? tags_q[ridx_q][way_q] : '0;
          end else begin
            evict_valid_q <= 1'b0;
            evict_tag_q   <= '0;
          end
          resp_hit_q <= hit_q;
          resp_way_q <= way_q;
        end
        S_RESP: begin
          // Raised on the first RESP cycle, dropped on the handshake edge.
          resp_valid_q <= !(resp_valid_q && resp_ready);
        end
        default: ;
      endcase
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_hit    = resp_hit_q;
  assign resp_way    = resp_way_q;
  assign evict_valid = evict_valid_q;
  assign evict_tag   = evict_tag_q;
  assign tag_row     = tag_row_q;

endmodule
`default_nettype wire
